// File: rtl/uart_rx_deframer_pkg.sv
// Shared definitions for the UART receive path: FSM state encoding and
// baud-timing helpers, also used by the matching TX block.
package uart_rx_deframer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } rx_state_e;

  // Clock cycles per serial symbol.
  function automatic int symbol_edge_time(input int clock_freq, input int baud_rate);
    return clock_freq / baud_rate;
  endfunction

  // Offset from a symbol edge to its centre.
  function automatic int sample_time(input int clock_freq, input int baud_rate);
    return symbol_edge_time(clock_freq, baud_rate) / 2;
  endfunction

endpackage

// File: rtl/uart_rx_deframer_sync_ff.sv
// Multi-flop synchronizer for an asynchronous single-bit input; the chain
// resets to RESET_VAL so an idle-high line does not look like a start bit.
module uart_rx_deframer_sync_ff #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_q;
  logic [STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[STAGES-2:0], d};
  end

  // NOTE: state is updated with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign q = sync_q[STAGES-1];

endmodule

// File: rtl/uart_rx_deframer.sv
// 8N1 UART receiver: synchronizes serial_in, deframes bytes and presents them
// on a ready/valid port with framing-error and overrun pulses.
module uart_rx_deframer
  import uart_rx_deframer_pkg::*;
#(
  parameter int CLOCK_FREQ  = 50_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       serial_in,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  input  logic       data_out_ready,
  output logic       framing_error,
  output logic       overrun
);

  localparam int SYMBOL_EDGE_TIME = symbol_edge_time(CLOCK_FREQ, BAUD_RATE);
  localparam int SAMPLE_TIME      = sample_time(CLOCK_FREQ, BAUD_RATE);
  localparam int CNT_W            = $clog2(SYMBOL_EDGE_TIME);

  localparam logic [CNT_W-1:0] CNT_SAMPLE = CNT_W'(SAMPLE_TIME - 1);
  localparam logic [CNT_W-1:0] CNT_SYMBOL = CNT_W'(SYMBOL_EDGE_TIME - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  logic             rx_s;
  rx_state_e        state_q, state_d;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             valid_q, valid_d;
  logic             framing_error_q, framing_error_d;
  logic             overrun_q, overrun_d;
  logic             stop_sample;

  uart_rx_deframer_sync_ff #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (1'b1)
  ) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (serial_in),
    .q   (rx_s)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= ST_IDLE;
      clk_cnt_q       <= '0;
      bit_idx_q       <= '0;
      shift_q         <= '0;
      data_out_q      <= '0;
      valid_q         <= 1'b0;
      framing_error_q <= 1'b0;
      overrun_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      clk_cnt_q       <= clk_cnt_d;
      bit_idx_q       <= bit_idx_d;
      shift_q         <= shift_d;
      data_out_q      <= data_out_d;
      valid_q         <= valid_d;
      framing_error_q <= framing_error_d;
      overrun_q       <= overrun_d;
    end
  end

  // NOTE: every signal gets a default first so no path through the case infers a latch.
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    unique case (state_q)
      ST_IDLE: begin
        if (!rx_s) begin
          state_d   = ST_START;
          clk_cnt_d = '0;
        end
      end
      ST_START: begin
        if (clk_cnt_q == CNT_SAMPLE) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      ST_DATA: begin
        if (clk_cnt_q == CNT_SYMBOL) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s;
          bit_idx_d          = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) state_d = ST_STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      ST_STOP: begin
        // Leaving at mid stop bit lets the next start edge be caught immediately.
        if (clk_cnt_q == CNT_SYMBOL) begin
          clk_cnt_d = '0;
          state_d   = rx_s ? ST_IDLE : ST_BREAK;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_ONE;
        end
      end
      ST_BREAK: begin
        if (rx_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign stop_sample = (state_q == ST_STOP) && (clk_cnt_q == CNT_SYMBOL);

  always_comb begin
    data_out_d      = data_out_q;
    valid_d         = valid_q;
    framing_error_d = 1'b0;
    overrun_d       = 1'b0;
    if (valid_q && data_out_ready) valid_d = 1'b0;
    if (stop_sample) begin
      if (rx_s) begin
        data_out_d = shift_q;
        valid_d    = 1'b1;
        overrun_d  = valid_q && !data_out_ready;
      end else begin
        framing_error_d = 1'b1;
      end
    end
  end

  assign data_out       = data_out_q;
  assign data_out_valid = valid_q;
  assign framing_error  = framing_error_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Scoreboard bench for uart_rx_deframer; the line runs at 250 kbaud from a
// 50 MHz clock (200 cycles per bit) to keep the run short.
module tb_uart_rx_deframer;

  localparam int CLOCK_FREQ  = 50_000_000;
  localparam int BAUD_RATE   = 250_000;
  localparam int SYNC_STAGES = 2;
  localparam int BIT         = CLOCK_FREQ / BAUD_RATE;
  localparam int HALF        = BIT / 2;
  localparam int LATENCY     = SYNC_STAGES + HALF + 9 * BIT;

  logic       clk;
  logic       rst;
  logic       serial_in;
  logic [7:0] data_out;
  logic       data_out_valid;
  logic       data_out_ready;
  logic       framing_error;
  logic       overrun;

  int checks = 0;
  int errors = 0;

  logic [7:0] exp_q[$];
  int cyc = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int xfer_cnt = 0;
  int valid_cycles = 0;
  int last_rise_cyc = 0;
  int fall_cyc = 0;
  logic valid_prev = 1'b0;

  uart_rx_deframer #(
    .CLOCK_FREQ  (CLOCK_FREQ),
    .BAUD_RATE   (BAUD_RATE),
    .SYNC_STAGES (SYNC_STAGES)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .serial_in      (serial_in),
    .data_out       (data_out),
    .data_out_valid (data_out_valid),
    .data_out_ready (data_out_ready),
    .framing_error  (framing_error),
    .overrun        (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: counts pulses and pops the scoreboard on every accepted byte.
  always @(negedge clk) begin
    if (!rst) begin
      if (framing_error) fe_cnt++;
      if (overrun) ov_cnt++;
      if (data_out_valid) valid_cycles++;
      if (data_out_valid && !valid_prev) last_rise_cyc = cyc;
      if (data_out_valid && data_out_ready) begin
        logic [7:0] exp;
        xfer_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_byte: got %02h, scoreboard empty", data_out);
        end else begin
          exp = exp_q.pop_front();
          if (data_out !== exp) begin
            errors++;
            $display("FAIL byte_value: got %02h, expected %02h", data_out, exp);
          end
        end
      end
    end
    valid_prev = data_out_valid;
  end

  initial begin
    #900_000;
    $display("FAIL watchdog: simulation still running at cycle %0d", cyc);
    $fatal(1, "watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int stop_cycles);
    serial_in = 1'b0;
    fall_cyc  = cyc;
    tick(BIT);
    for (int i = 0; i < 8; i++) begin
      serial_in = b[i];
      tick(BIT);
    end
    serial_in = stop_bit;
    tick(stop_cycles);
    serial_in = 1'b1;
  endtask

  task automatic wait_drain(input string name);
    int budget = 4 * BIT;
    while (exp_q.size() != 0 && budget > 0) begin
      tick(1);
      budget--;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d bytes still pending, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    serial_in = 1'b1;
    data_out_ready = 1'b1;
    tick(3);
    checks++;
    if (data_out !== 8'h00 || data_out_valid !== 1'b0 || framing_error !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: got data=%02h valid=%b fe=%b ov=%b, expected 00 0 0 0",
               data_out, data_out_valid, framing_error, overrun);
    end
    rst = 1'b0;
    tick(BIT);
    checks++;
    if (data_out_valid !== 1'b0 || fe_cnt != 0 || ov_cnt != 0) begin
      errors++;
      $display("FAIL idle_after_reset: got valid=%b fe=%0d ov=%0d, expected 0 0 0",
               data_out_valid, fe_cnt, ov_cnt);
    end
  endtask

  task automatic test_single();
    int x0 = xfer_cnt, v0 = valid_cycles, f0 = fe_cnt, o0 = ov_cnt, lat;
    exp_q.push_back(8'h61);
    send_frame(8'h61, 1'b1, BIT);
    tick(BIT);
    wait_drain("single");
    checks++;
    if (xfer_cnt - x0 != 1 || valid_cycles - v0 != 1) begin
      errors++;
      $display("FAIL single_valid: got %0d transfers over %0d valid cycles, expected 1 and 1",
               xfer_cnt - x0, valid_cycles - v0);
    end
    checks++;
    if (fe_cnt != f0 || ov_cnt != o0) begin
      errors++;
      $display("FAIL single_pulses: got fe=%0d ov=%0d, expected 0 0", fe_cnt - f0, ov_cnt - o0);
    end
    lat = last_rise_cyc - fall_cyc;
    checks++;
    if (lat < LATENCY - 1 || lat > LATENCY + 1) begin
      errors++;
      $display("FAIL single_latency: got %0d cycles, expected %0d +/- 1", lat, LATENCY);
    end
  endtask

  task automatic test_back_to_back();
    int x0 = xfer_cnt, f0 = fe_cnt, o0 = ov_cnt;
    for (int i = 0; i < 10; i++) begin
      logic [7:0] b;
      b = 8'h61 + 8'(i);
      exp_q.push_back(b);
      send_frame(b, 1'b1, BIT);
    end
    tick(BIT);
    wait_drain("b2b");
    checks++;
    if (xfer_cnt - x0 != 10) begin
      errors++;
      $display("FAIL b2b_count: got %0d transfers, expected 10", xfer_cnt - x0);
    end
    checks++;
    if (fe_cnt != f0 || ov_cnt != o0) begin
      errors++;
      $display("FAIL b2b_pulses: got fe=%0d ov=%0d, expected 0 0", fe_cnt - f0, ov_cnt - o0);
    end
  endtask

  task automatic test_glitch();
    int x0 = xfer_cnt, f0 = fe_cnt;
    serial_in = 1'b0;
    tick(HALF / 2);
    serial_in = 1'b1;
    tick(2 * BIT);
    checks++;
    if (xfer_cnt != x0 || fe_cnt != f0 || data_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL glitch_rejected: got xfers=%0d fe=%0d valid=%b, expected 0 0 0",
               xfer_cnt - x0, fe_cnt - f0, data_out_valid);
    end
    exp_q.push_back(8'h55);
    send_frame(8'h55, 1'b1, BIT);
    tick(BIT);
    wait_drain("glitch");
    checks++;
    if (xfer_cnt - x0 != 1) begin
      errors++;
      $display("FAIL glitch_followup: got %0d transfers, expected 1", xfer_cnt - x0);
    end
  endtask

  task automatic test_framing();
    int x0 = xfer_cnt, f0 = fe_cnt, o0 = ov_cnt;
    send_frame(8'hA5, 1'b0, 2 * BIT);
    tick(BIT);
    checks++;
    if (fe_cnt - f0 != 1) begin
      errors++;
      $display("FAIL framing_pulse: got %0d pulses, expected 1", fe_cnt - f0);
    end
    checks++;
    if (xfer_cnt != x0 || ov_cnt != o0) begin
      errors++;
      $display("FAIL framing_drop: got xfers=%0d ov=%0d, expected 0 0", xfer_cnt - x0, ov_cnt - o0);
    end
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1, BIT);
    tick(BIT);
    wait_drain("framing");
    checks++;
    if (xfer_cnt - x0 != 1 || fe_cnt - f0 != 1) begin
      errors++;
      $display("FAIL framing_recovery: got xfers=%0d fe=%0d, expected 1 1", xfer_cnt - x0, fe_cnt - f0);
    end
  endtask

  task automatic test_overrun();
    int x0 = xfer_cnt, o0 = ov_cnt;
    data_out_ready = 1'b0;
    send_frame(8'h11, 1'b1, BIT);
    checks++;
    if (data_out_valid !== 1'b1 || data_out !== 8'h11 || ov_cnt != o0) begin
      errors++;
      $display("FAIL overrun_first: got valid=%b data=%02h ov=%0d, expected 1 11 0",
               data_out_valid, data_out, ov_cnt - o0);
    end
    exp_q.push_back(8'h22);
    send_frame(8'h22, 1'b1, BIT);
    checks++;
    if (ov_cnt - o0 != 1) begin
      errors++;
      $display("FAIL overrun_pulse: got %0d pulses, expected 1", ov_cnt - o0);
    end
    checks++;
    if (data_out_valid !== 1'b1 || data_out !== 8'h22 || xfer_cnt != x0) begin
      errors++;
      $display("FAIL overrun_hold: got valid=%b data=%02h xfers=%0d, expected 1 22 0",
               data_out_valid, data_out, xfer_cnt - x0);
    end
    data_out_ready = 1'b1;
    tick(BIT);
    wait_drain("overrun");
    checks++;
    if (xfer_cnt - x0 != 1 || data_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL overrun_release: got xfers=%0d valid=%b, expected 1 0",
               xfer_cnt - x0, data_out_valid);
    end
  endtask

  task automatic test_reset_midframe();
    int x0 = xfer_cnt, f0 = fe_cnt, o0 = ov_cnt;
    serial_in = 1'b0;
    tick(BIT);
    serial_in = 1'b1;
    tick(3 * BIT + HALF + SYNC_STAGES + 2);
    rst = 1'b1;
    tick(1);
    checks++;
    if (data_out_valid !== 1'b0 || framing_error !== 1'b0 || overrun !== 1'b0) begin
      errors++;
      $display("FAIL midframe_reset: got valid=%b fe=%b ov=%b, expected 0 0 0",
               data_out_valid, framing_error, overrun);
    end
    tick(1);
    rst = 1'b0;
    tick(6 * BIT);
    checks++;
    if (xfer_cnt != x0 || fe_cnt != f0 || ov_cnt != o0 || data_out_valid !== 1'b0) begin
      errors++;
      $display("FAIL midframe_discard: got xfers=%0d fe=%0d ov=%0d valid=%b, expected 0 0 0 0",
               xfer_cnt - x0, fe_cnt - f0, ov_cnt - o0, data_out_valid);
    end
    exp_q.push_back(8'h7E);
    send_frame(8'h7E, 1'b1, BIT);
    tick(BIT);
    wait_drain("midframe");
    checks++;
    if (xfer_cnt - x0 != 1) begin
      errors++;
      $display("FAIL midframe_followup: got %0d transfers, expected 1", xfer_cnt - x0);
    end
  endtask

  initial begin
    rst = 1'b1;
    serial_in = 1'b1;
    data_out_ready = 1'b1;
    @(posedge clk);
    #1;
    test_reset();
    test_single();
    test_back_to_back();
    test_glitch();
    test_framing();
    test_overrun();
    test_reset_midframe();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
